// File: rtl/fme_arbiter_pkg.sv
// fme_arbiter_pkg
//   Shared definitions for the FastModExp arbiter: FSM state encodings,
//   default datapath width and requester port indices.
//   No ports; imported by fme_arbiter and rr_pick2.
package fme_arbiter_pkg;

   localparam int RSA_W = 32;

   // Port indices double as the owner / last-grant encoding.
   localparam logic PORT_ENC = 1'b0;
   localparam logic PORT_DEC = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LAUNCH  = 2'd1,
      S_WAIT    = 2'd2,
      S_DELIVER = 2'd3
   } state_t;

endpackage

// File: rtl/fme_arbiter_rr_pick2.sv
// rr_pick2
//   Combinational two-way round-robin chooser.
//   Ports:
//     req0, req1 : request levels
//     last       : port granted most recently (loses a tie)
//     owner      : chosen port index (meaningful only when valid)
//     valid      : at least one request present
module rr_pick2
   import fme_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic owner,
   output logic valid
);

   // Tie goes to the port that was not served last; otherwise the lone requester.
   always_comb begin
      valid = req0 | req1;
      if (req0 && req1) begin
         owner = ~last;
      end else if (req1) begin
         owner = PORT_DEC;
      end else begin
         owner = PORT_ENC;
      end
   end

endmodule

// File: rtl/fme_arbiter.sv
// fme_arbiter
//   Shares one FastModExp core between the encryption port (0) and the
//   decryption port (1). Round-robin grant, operand latch, start/done
//   sequencing, result returned only to the owning port.
//   Optional build macro: FME_TIMEOUT_EN enables a WAIT-state watchdog that
//   aborts after TIMEOUT_CYCLES cycles, delivering result 0 with a timeout pulse.
//   Ports:
//     clk, rst                    : clock, asynchronous active-high reset
//     req0/1, base0/1, exp0/1,
//     mod0/1                      : requester level request and operands
//     gnt0/1                      : 1-cycle pulse, operands captured
//     done0/1, res0/1             : 1-cycle completion pulse, held result
//     fme_start, fme_base,
//     fme_exponent, fme_modulo    : core launch pulse and latched operands
//     fme_result, fme_done        : core result and completion tick
//     busy                        : high outside IDLE
//     timeout                     : watchdog abort pulse (0 without macro)
module fme_arbiter
   import fme_arbiter_pkg::*;
#(
   parameter int W              = RSA_W,
   parameter int TIMEOUT_CYCLES = 8192
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic [W-1:0] base0,
   input  logic [W-1:0] base1,
   input  logic [W-1:0] exp0,
   input  logic [W-1:0] exp1,
   input  logic [W-1:0] mod0,
   input  logic [W-1:0] mod1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         done0,
   output logic         done1,
   output logic [W-1:0] res0,
   output logic [W-1:0] res1,
   output logic         fme_start,
   output logic [W-1:0] fme_base,
   output logic [W-1:0] fme_exponent,
   output logic [W-1:0] fme_modulo,
   input  logic [W-1:0] fme_result,
   input  logic         fme_done,
   output logic         busy,
   output logic         timeout
);

   state_t state;
   state_t next_state;
   logic   last_gnt;     // also the current owner once a grant has been made
   logic   pick_owner;
   logic   pick_valid;
   logic   wd_expire;
   logic   gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt, start_nxt, busy_nxt;

   rr_pick2 u_pick (
      .req0  (req0),
      .req1  (req1),
      .last  (last_gnt),
      .owner (pick_owner),
      .valid (pick_valid)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; fme_done is only honoured in WAIT.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (pick_valid) begin
               next_state = S_LAUNCH;
            end else begin
               next_state = S_IDLE;
            end
         end
         S_LAUNCH:  next_state = S_WAIT;
         S_WAIT: begin
            if (fme_done || wd_expire) begin
               next_state = S_DELIVER;
            end else begin
               next_state = S_WAIT;
            end
         end
         S_DELIVER: next_state = S_IDLE;
         default:   next_state = S_IDLE;
      endcase
   end

   // Output decode from the next state so the pulses come straight off flops.
   // Entering LAUNCH only happens from IDLE, where pick_owner is the new owner;
   // entering DELIVER happens after the grant, where last_gnt holds the owner.
   always_comb begin
      gnt0_nxt  = 1'b0;
      gnt1_nxt  = 1'b0;
      done0_nxt = 1'b0;
      done1_nxt = 1'b0;
      start_nxt = 1'b0;
      busy_nxt  = (next_state != S_IDLE);
      if (next_state == S_LAUNCH) begin
         start_nxt = 1'b1;
         if (pick_owner == PORT_ENC) begin
            gnt0_nxt = 1'b1;
         end else begin
            gnt1_nxt = 1'b1;
         end
      end else if (next_state == S_DELIVER) begin
         if (last_gnt == PORT_ENC) begin
            done0_nxt = 1'b1;
         end else begin
            done1_nxt = 1'b1;
         end
      end else begin
         start_nxt = 1'b0;
      end
   end

   // Registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         fme_start <= 1'b0;
         busy      <= 1'b0;
      end else begin
         gnt0      <= gnt0_nxt;
         gnt1      <= gnt1_nxt;
         done0     <= done0_nxt;
         done1     <= done1_nxt;
         fme_start <= start_nxt;
         busy      <= busy_nxt;
      end
   end

   // Operand bank, round-robin history and per-port result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt     <= PORT_DEC;
         fme_base     <= {W{1'b0}};
         fme_exponent <= {W{1'b0}};
         fme_modulo   <= {W{1'b0}};
         res0         <= {W{1'b0}};
         res1         <= {W{1'b0}};
      end else begin
         if ((state == S_IDLE) && pick_valid) begin
            last_gnt     <= pick_owner;
            fme_base     <= (pick_owner == PORT_ENC) ? base0 : base1;
            fme_exponent <= (pick_owner == PORT_ENC) ? exp0  : exp1;
            fme_modulo   <= (pick_owner == PORT_ENC) ? mod0  : mod1;
         end
         if ((state == S_WAIT) && fme_done) begin
            if (last_gnt == PORT_ENC) begin
               res0 <= fme_result;
            end else begin
               res1 <= fme_result;
            end
         end else if (wd_expire) begin
            if (last_gnt == PORT_ENC) begin
               res0 <= {W{1'b0}};
            end else begin
               res1 <= {W{1'b0}};
            end
         end
      end
   end

`ifdef FME_TIMEOUT_EN
   localparam int             CW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]  WD_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] wd_cnt;

   // wd_cnt holds the number of WAIT cycles already completed, so the
   // TIMEOUT_CYCLES-th WAIT cycle is the one that sees WD_LAST.
   assign wd_expire = (state == S_WAIT) && (wd_cnt == WD_LAST) && !fme_done;

   // Watchdog counter: cleared at launch, advancing once per WAIT cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt <= {CW{1'b0}};
      end else if (state == S_LAUNCH) begin
         wd_cnt <= {CW{1'b0}};
      end else if (state == S_WAIT) begin
         wd_cnt <= wd_cnt + CW'(1);
      end
   end

   // Timeout pulse lines up with the DELIVER cycle of an aborted operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timeout <= 1'b0;
      end else begin
         timeout <= wd_expire;
      end
   end
`else
   assign wd_expire = 1'b0;
   assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_fme_arbiter.sv
// tb_fme_arbiter
//   Directed self-checking bench for fme_arbiter with a behavioural
//   FastModExp core model (fixed latency, can be muted to stall WAIT).
//   Build with or without FME_TIMEOUT_EN; the final scenario adapts.
module tb_fme_arbiter;

   localparam int W   = 32;
   localparam int LAT = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0, req1;
   logic [W-1:0] base0, base1, exp0, exp1, mod0, mod1;
   logic         gnt0, gnt1, done0, done1;
   logic [W-1:0] res0, res1;
   logic         fme_start;
   logic [W-1:0] fme_base, fme_exponent, fme_modulo, fme_result;
   logic         fme_done;
   logic         busy, timeout;

   logic         core_en;
   logic         core_done;
   logic [W-1:0] core_res;
   logic         spur_done;
   logic [W-1:0] spur_res;
   int           core_cnt;
   logic [W-1:0] core_pending;

   int total = 0;
   int bad   = 0;

   assign fme_done   = core_done | spur_done;
   assign fme_result = spur_done ? spur_res : core_res;

   fme_arbiter #(.W(W), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1),
      .base0(base0), .base1(base1),
      .exp0(exp0), .exp1(exp1),
      .mod0(mod0), .mod1(mod1),
      .gnt0(gnt0), .gnt1(gnt1),
      .done0(done0), .done1(done1),
      .res0(res0), .res1(res1),
      .fme_start(fme_start),
      .fme_base(fme_base), .fme_exponent(fme_exponent), .fme_modulo(fme_modulo),
      .fme_result(fme_result), .fme_done(fme_done),
      .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                           input logic [W-1:0] m);
      logic [63:0] r;
      logic [63:0] x;
      r = 64'd1;
      x = {32'd0, b} % {32'd0, m};
      for (int i = 0; i < W; i++) begin
         if (e[i]) r = (r * x) % {32'd0, m};
         x = (x * x) % {32'd0, m};
      end
      return r[W-1:0];
   endfunction

   // Core model: sees fme_start in the LAUNCH cycle, answers LAT cycles later.
   initial begin
      core_done    = 1'b0;
      core_res     = '0;
      core_cnt     = 0;
      core_pending = '0;
      forever begin
         @(negedge clk);
         core_done = 1'b0;
         if (rst) begin
            core_cnt = 0;
         end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
               core_done = 1'b1;
               core_res  = core_pending;
            end
         end else if (fme_start && core_en) begin
            core_pending = modexp(fme_base, fme_exponent, fme_modulo);
            core_cnt     = LAT;
         end
      end
   end

   task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Raise one request, check the grant/start one cycle later, then withdraw it.
   task automatic launch(input bit port, input logic [W-1:0] b, input logic [W-1:0] e,
                         input logic [W-1:0] m, input string tag);
      if (port) begin
         req1 = 1'b1; base1 = b; exp1 = e; mod1 = m;
      end else begin
         req0 = 1'b1; base0 = b; exp0 = e; mod0 = m;
      end
      @(negedge clk);
      check_val({tag, "_gnt"},   port ? gnt1 : gnt0, 1);
      check_val({tag, "_ngnt"},  port ? gnt0 : gnt1, 0);
      check_val({tag, "_start"}, fme_start, 1);
      check_val({tag, "_base"},  fme_base, b);
      check_val({tag, "_exp"},   fme_exponent, e);
      check_val({tag, "_mod"},   fme_modulo, m);
      if (port) req1 = 1'b0;
      else      req0 = 1'b0;
   endtask

   // Wait (bounded) for the port's done pulse; the other port must stay quiet.
   task automatic wait_done(input bit port, input string tag);
      bit seen  = 1'b0;
      bit other = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (port ? done1 : done0) seen = 1'b1;
         if (port ? done0 : done1) other = 1'b1;
      end
      check_val({tag, "_done"},  {31'd0, seen}, 1);
      check_val({tag, "_other"}, {31'd0, other}, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got=stuck expected=finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      int order [4];
      int ng;
      int cyc;
      bit any;
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      base0 = '0; base1 = '0; exp0 = '0; exp1 = '0; mod0 = '0; mod1 = '0;
      core_en = 1'b1; spur_done = 1'b0; spur_res = '0;
      repeat (3) @(negedge clk);
      check_val("rst_busy",  busy, 0);
      check_val("rst_gnt0",  gnt0, 0);
      check_val("rst_done0", done0, 0);
      check_val("rst_res0",  res0, 0);
      check_val("rst_start", fme_start, 0);
      check_val("rst_tmo",   timeout, 0);
      rst = 1'b0;
      @(negedge clk);

      // 1: encrypt 65^17 mod 3233
      launch(1'b0, 32'd65, 32'd17, 32'd3233, "s1");
      wait_done(1'b0, "s1");
      check_val("s1_res0", res0, 32'd2790);
      @(negedge clk);
      check_val("s1_pulse", done0, 0);
      check_val("s1_idle",  busy, 0);

      // 2: decrypt 2790^413 mod 3233, res0 untouched
      launch(1'b1, 32'd2790, 32'd413, 32'd3233, "s2");
      wait_done(1'b1, "s2");
      check_val("s2_res1", res1, 32'd65);
      check_val("s2_res0", res0, 32'd2790);

      // 3: simultaneous held requests after reset alternate 0,1,0,1
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req0 = 1'b1; base0 = 32'd65;   exp0 = 32'd17;  mod0 = 32'd3233;
      req1 = 1'b1; base1 = 32'd2790; exp1 = 32'd413; mod1 = 32'd3233;
      for (int k = 0; k < 4; k++) order[k] = -1;
      ng = 0;
      for (int i = 0; i < 200 && ng < 4; i++) begin
         @(negedge clk);
         if (gnt0) begin order[ng] = 0; ng++; end
         else if (gnt1) begin order[ng] = 1; ng++; end
      end
      req0 = 1'b0; req1 = 1'b0;
      check_val("s3_ngrants", ng, 4);
      check_val("s3_g0", order[0], 0);
      check_val("s3_g1", order[1], 1);
      check_val("s3_g2", order[2], 0);
      check_val("s3_g3", order[3], 1);
      wait_done(1'b1, "s3");
      check_val("s3_res1", res1, 32'd65);
      check_val("s3_res0", res0, 32'd2790);
      @(negedge clk);

      // 4: operands change right after grant; latched copy must be used
      launch(1'b0, 32'd4, 32'd13, 32'd497, "s4");
      base0 = 32'd99;
      wait_done(1'b0, "s4");
      check_val("s4_res0", res0, 32'd445);
      check_val("s4_latch", fme_base, 32'd4);
      @(negedge clk);

      // 5: reset in WAIT clears everything at once
      launch(1'b0, 32'd65, 32'd17, 32'd3233, "s5");
      @(negedge clk);
      check_val("s5_busy_pre", busy, 1);
      rst = 1'b1;
      #1;
      check_val("s5_busy",  busy, 0);
      check_val("s5_start", fme_start, 0);
      check_val("s5_gnt0",  gnt0, 0);
      check_val("s5_done0", done0, 0);
      check_val("s5_res0",  res0, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      launch(1'b0, 32'd65, 32'd17, 32'd3233, "s5b");
      wait_done(1'b0, "s5b");
      check_val("s5b_res0", res0, 32'd2790);
      @(negedge clk);

      // 6: core never answers
      core_en = 1'b0;
      launch(1'b0, 32'd65, 32'd17, 32'd3233, "s6");
`ifdef FME_TIMEOUT_EN
      cyc = 0;
      for (int i = 1; i <= 40 && cyc == 0; i++) begin
         @(negedge clk);
         if (done0 || timeout) cyc = i;
      end
      check_val("s6_cycles", cyc, 17);
      check_val("s6_tmo",    timeout, 1);
      check_val("s6_done0",  done0, 1);
      check_val("s6_res0",   res0, 0);
      @(negedge clk);
      check_val("s6_tmo_pulse", timeout, 0);
      spur_res = 32'd1234; spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      any = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done0 || busy) any = 1'b1;
      end
      check_val("s6_late_ignored", {31'd0, any}, 0);
      check_val("s6_res0_kept", res0, 0);
`else
      any = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done0 || timeout) any = 1'b1;
      end
      check_val("s6_no_abort", {31'd0, any}, 0);
      check_val("s6_busy", busy, 1);
      spur_res = 32'd1234; spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      check_val("s6_done0", done0, 1);
      check_val("s6_res0",  res0, 32'd1234);
      check_val("s6_tmo",   timeout, 0);
`endif
      core_en = 1'b1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
